microwave_oven_ctrl_p: RTL
==========================

// Module: microwave_oven_ctrl_p
// PURPOSE
//   Parametrised microwave controller: one-hot keypad time entry, mm:ss BCD countdown,
//   run/pause/done FSM, door interlock, power-level duty cycling of the magnetron,
//   end-of-cook beeper and 7-segment drive. Generalises the fixed 1-minute-digit oven
//   to N minute digits, adds power levels and start/stop edge detection.
//   Sits between front-panel debounced inputs and magnetron/display drivers.
// PARAMETERS
//   MIN_DIGITS   1    number of BCD minute digits (1..3)
//   CLK_PER_SEC  100  clock cycles per second (100 = 10 ms clock period)
//   POWER_LEVELS 10   duty window length in seconds; also max power level
//   BEEP_SECS    3    seconds done_beep stays high after countdown reaches zero
// PORTS
//   clock          in   1             system clock, rising edge
//   clearn         in   1             async active-low reset/clear
//   keypad         in   10            one-hot digit keys, bit k = digit k
//   startn         in   1             start, active low
//   stopn          in   1             stop/pause, active low
//   door_closed    in   1             1 = door closed
//   power_level    in   4             requested power, sampled on start
//   mag_on         out  1             magnetron enable
//   done_beep      out  1             end-of-cook beeper
//   cooking        out  1             1 in COOK state
//   min_segs       out  7*MIN_DIGITS  minute digits, digit i at [7i+6:7i]
//   sec_tens_segs  out  7             seconds tens digit
//   sec_ones_segs  out  7             seconds ones digit
// BEHAVIOUR
//   - Reset (clearn=0, async): state IDLE, all digits 0, tick/window counters 0, power
//     reg = POWER_LEVELS, mag_on=0, done_beep=0, cooking=0; displays show 0.
//   - Segments active-high, bit0=a..bit6=g; 0=7'h3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D
//     7=07 8=7F 9=6F. Combinational decode from registered digits.
//   - Key press = registered keypad goes 0 -> exactly one bit set; multi-bit or held
//     values generate no press. startn/stopn act on registered 1->0 edge only.
//   - IDLE: press shifts digits left: key->ones, ones->tens, tens->min[0],
//     min[i]->min[i+1], top minute digit discarded. Tens 6..9 legal (0:75 = 75 s).
//   - IDLE + start edge + door_closed + time!=0 -> COOK; latch power_level (0 or
//     >POWER_LEVELS clamps to POWER_LEVELS); tick and window counters cleared.
//     Start with door open or time 0 ignored.
//   - COOK: tick counts 0..CLK_PER_SEC-1; at wrap time decrements one second:
//     ones>0 ones-1; else ones=9 and tens>0 tens-1; else tens=5, ones=9, minutes
//     decrement as BCD with borrow. Window counter 0..POWER_LEVELS-1 advances each second.
//   - mag_on = (state==COOK) & door_closed & (window < power), registered, AND'd
//     combinationally with door_closed: door open drops mag_on same cycle.
//   - COOK + door_closed==0 or stop edge -> PAUSED next cycle; digits, tick, window held.
//   - PAUSED + start edge + door_closed -> COOK (resume, counters kept).
//     PAUSED + stop edge -> IDLE with digits cleared to 0. Keypad ignored.
//   - Decrement reaching all-zero -> DONE same edge; mag_on 0; done_beep 1 for
//     BEEP_SECS*CLK_PER_SEC cycles, then IDLE (digits 0). Stop edge in DONE -> IDLE
//     immediately, beep off. Keypad/start ignored in DONE.
//   - Simultaneous start and stop edges: stop wins. Start held low never re-triggers.
//   - clearn mid-COOK: mag_on drops asynchronously, full reset state.
// TESTING  (MIN_DIGITS=1, CLK_PER_SEC=100, POWER_LEVELS=10, BEEP_SECS=3, 10 ms clock)
//   - Keys 2,0,6 pulsed 10 ms each, gaps 0 -> display 2:06; keypad held 6 for 50 cycles
//     -> only one shift; keypad 10'b0000000110 -> no change.
//   - 2:06, power 0, start -> mag_on continuous; after 126 s done_beep=1, display 0:00,
//     beep low after 300 cycles, state IDLE; no restart while startn held low.
//   - 0:15, power 3, start -> mag_on high 3 s of every 10 s window (30% duty).
//   - Cook 1:00, open door at 10.5 s -> mag_on 0 same cycle, display frozen 0:50;
//     close door: stays paused; start -> resumes 0:50->0:49 after remaining 50 cycles.
//   - Borrow: 1:00 -> 0:59 after 1 s; 0:75 enters and counts 75 s; start at 0:00
//     ignored; start with door open ignored.
//   - clearn pulse 20 ms during COOK -> mag_on 0 immediately, display 0:00, IDLE;
//     stop,stop -> PAUSED then IDLE with 0:00.

Source files
------------

// File: rtl/microwave_oven_ctrl_p.sv
// Microwave controller: keypad mm:ss entry, BCD countdown, run/pause/done FSM, door interlock, power duty cycling.
// Inputs registered once, edges act on the following clock; mag_on registered, gated combinationally by the door.
module microwave_oven_ctrl_p #(
    parameter int MIN_DIGITS   = 1,
    parameter int CLK_PER_SEC  = 100,
    parameter int POWER_LEVELS = 10,
    parameter int BEEP_SECS    = 3
) (
    input  logic                    clock,
    input  logic                    clearn,
    input  logic [9:0]              keypad,
    input  logic                    startn,
    input  logic                    stopn,
    input  logic                    door_closed,
    input  logic [3:0]              power_level,
    output logic                    mag_on,
    output logic                    done_beep,
    output logic                    cooking,
    output logic [7*MIN_DIGITS-1:0] min_segs,
    output logic [6:0]              sec_tens_segs,
    output logic [6:0]              sec_ones_segs
);

    localparam int TICK_W   = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam int BEEP_CYC = BEEP_SECS * CLK_PER_SEC;
    localparam int BEEP_W   = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CLK_PER_SEC - 1);
    localparam logic [BEEP_W-1:0] BEEP_MAX = BEEP_W'(BEEP_CYC - 1);
    localparam logic [3:0]        PWR_MAX  = 4'(POWER_LEVELS);
    localparam logic [3:0]        WIN_MAX  = 4'(POWER_LEVELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_COOK, S_PAUSED, S_DONE} state_t;

    state_t                      r_state, w_state_nxt;
    logic [9:0]                  r_key, r_key_d;
    logic                        r_startn, r_startn_d, r_stopn, r_stopn_d;
    logic [MIN_DIGITS-1:0][3:0]  r_min, w_dec_min;
    logic [3:0]                  r_tens, r_ones, w_dec_tens, w_dec_ones;
    logic [TICK_W-1:0]           r_tick, w_tick_nxt;
    logic [3:0]                  r_win, w_win_nxt, r_pow, w_pow_nxt;
    logic [BEEP_W-1:0]           r_beep;
    logic                        r_mag;
    logic                        w_press, w_start, w_stop, w_time_zero, w_last, w_sec_dec;
    logic [3:0]                  w_key_bcd;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'h3F;
            4'd1:    f_seg = 7'h06;
            4'd2:    f_seg = 7'h5B;
            4'd3:    f_seg = 7'h4F;
            4'd4:    f_seg = 7'h66;
            4'd5:    f_seg = 7'h6D;
            4'd6:    f_seg = 7'h7D;
            4'd7:    f_seg = 7'h07;
            4'd8:    f_seg = 7'h7F;
            4'd9:    f_seg = 7'h6F;
            default: f_seg = 7'h00;
        endcase
    endfunction

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            r_key      <= '0;
            r_key_d    <= '0;
            r_startn   <= 1'b1;
            r_startn_d <= 1'b1;
            r_stopn    <= 1'b1;
            r_stopn_d  <= 1'b1;
        end else begin
            r_key      <= keypad;
            r_key_d    <= r_key;
            r_startn   <= startn;
            r_startn_d <= r_startn;
            r_stopn    <= stopn;
            r_stopn_d  <= r_stopn;
        end
    end

    // A press needs a clean 0 -> one-hot transition so held or chorded keys never repeat.
    assign w_press = (r_key_d == '0) && (r_key != '0) && ((r_key & (r_key - 10'd1)) == '0);
    assign w_start = r_startn_d & ~r_startn;
    assign w_stop  = r_stopn_d & ~r_stopn;

    always_comb begin
        w_key_bcd = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (r_key[k]) w_key_bcd = 4'(k);
        end
    end

    assign w_time_zero = (r_min == '0) && (r_tens == 4'd0) && (r_ones == 4'd0);
    assign w_last      = (r_min == '0) && (r_tens == 4'd0) && (r_ones == 4'd1);

    always_comb begin
        logic borrow;
        w_dec_min  = r_min;
        w_dec_tens = r_tens;
        w_dec_ones = r_ones;
        borrow     = 1'b0;
        if (r_ones != 4'd0) begin
            w_dec_ones = r_ones - 4'd1;
        end else begin
            w_dec_ones = 4'd9;
            if (r_tens != 4'd0) begin
                w_dec_tens = r_tens - 4'd1;
            end else begin
                w_dec_tens = 4'd5;
                borrow     = 1'b1;
            end
        end
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (borrow) begin
                if (r_min[i] == 4'd0) begin
                    w_dec_min[i] = 4'd9;
                end else begin
                    w_dec_min[i] = r_min[i] - 4'd1;
                    borrow       = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start && !w_stop && door_closed && !w_time_zero) w_state_nxt = S_COOK;
            S_COOK:   if (w_stop || !door_closed)                      w_state_nxt = S_PAUSED;
                      else if ((r_tick == TICK_MAX) && w_last)         w_state_nxt = S_DONE;
            S_PAUSED: if (w_stop)                                      w_state_nxt = S_IDLE;
                      else if (w_start && door_closed)                 w_state_nxt = S_COOK;
            S_DONE:   if (w_stop || (r_beep == BEEP_MAX))              w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mag_on    = r_mag & door_closed;
        cooking   = (r_state == S_COOK);
        done_beep = (r_state == S_DONE);
    end

    // Pausing freezes tick and window; a fresh start from IDLE clears them.
    assign w_sec_dec = (r_state == S_COOK) && (w_state_nxt != S_PAUSED) && (r_tick == TICK_MAX);

    always_comb begin
        w_tick_nxt = r_tick;
        w_win_nxt  = r_win;
        w_pow_nxt  = r_pow;
        if ((r_state == S_IDLE) && (w_state_nxt == S_COOK)) begin
            w_tick_nxt = '0;
            w_win_nxt  = 4'd0;
            w_pow_nxt  = ((power_level == 4'd0) || (power_level > PWR_MAX)) ? PWR_MAX : power_level;
        end else if ((r_state == S_COOK) && (w_state_nxt != S_PAUSED)) begin
            if (r_tick == TICK_MAX) begin
                w_tick_nxt = '0;
                w_win_nxt  = (r_win >= WIN_MAX) ? 4'd0 : r_win + 4'd1;
            end else begin
                w_tick_nxt = r_tick + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            r_min  <= '0;
            r_tens <= 4'd0;
            r_ones <= 4'd0;
            r_tick <= '0;
            r_win  <= 4'd0;
            r_pow  <= PWR_MAX;
            r_beep <= '0;
            r_mag  <= 1'b0;
        end else begin
            r_tick <= w_tick_nxt;
            r_win  <= w_win_nxt;
            r_pow  <= w_pow_nxt;
            r_beep <= (r_state == S_DONE) ? r_beep + 1'b1 : '0;
            r_mag  <= (w_state_nxt == S_COOK) && door_closed && (w_win_nxt < w_pow_nxt);
            if ((r_state == S_IDLE) && w_press && (w_state_nxt == S_IDLE)) begin
                for (int i = MIN_DIGITS - 1; i > 0; i--) begin
                    r_min[i] <= r_min[i-1];
                end
                r_min[0] <= r_tens;
                r_tens   <= r_ones;
                r_ones   <= w_key_bcd;
            end else if (w_sec_dec) begin
                r_min  <= w_dec_min;
                r_tens <= w_dec_tens;
                r_ones <= w_dec_ones;
            end else if ((r_state != S_IDLE) && (w_state_nxt == S_IDLE)) begin
                r_min  <= '0;
                r_tens <= 4'd0;
                r_ones <= 4'd0;
            end
        end
    end

    for (genvar g = 0; g < MIN_DIGITS; g++) begin : g_min_seg
        assign min_segs[7*g +: 7] = f_seg(r_min[g]);
    end
    assign sec_tens_segs = f_seg(r_tens);
    assign sec_ones_segs = f_seg(r_ones);

endmodule
